symbol_stream_feeder: RTL and testbench
=======================================

// Module: symbol_stream_feeder
// PURPOSE
//  Host-side driver for the STE automaton matcher. Accepts a byte stream and packs
//  byte pairs into 16-bit characters, first byte in [15:8]. Buffers characters in
//  a FIFO and issues them one per cycle with a step enable that gates the matcher's
//  active-state FFs. Turns the matcher's result bit back into offset-tagged report
//  records, so it sits at both ends of the matcher.
// PARAMETERS
//  FIFO_DEPTH  8   character FIFO entries (power of two, >=2)
//  CNT_W       32  width of character index / report offset counters
// PORTS
//  clock          in   1      single clock, all logic on posedge
//  reset_n        in   1      asynchronous, active-low reset
//  start          in   1      pulse: begin a new stream (honoured in IDLE/DONE only)
//  in_data        in   8      stream byte
//  in_valid       in   1      in_data valid
//  in_last        in   1      qualifies in_data as final byte of stream
//  in_ready       out  1      byte accepted when in_valid && in_ready
//  character      out  16     character presented to matcher (registered)
//  step           out  1      matcher advances this cycle (registered)
//  result         in   1      matcher report for the character on 'character'
//  report_valid   out  1      one-cycle report record strobe
//  report_offset  out  CNT_W  0-based character index of the reported character
//  char_count     out  CNT_W  characters stepped since start (saturating)
//  odd_drop       out  1      sticky: trailing unpaired byte was discarded
//  done           out  1      level: stream fully consumed, held until next start
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; FIFO empty; pair buffer empty.
//  States:
//   - IDLE: -> STREAM on start.
//   - STREAM: -> FLUSH on the accepted byte carrying in_last.
//   - FLUSH: -> DONE when FIFO is empty and step is 0.
//   - DONE: -> STREAM on start.
//  start in IDLE/DONE: clears FIFO, pair buffer, char_count, odd_drop and done,
//   then enters STREAM. start in STREAM/FLUSH is ignored.
//  in_ready = (state==STREAM) && FIFO not full; combinational from registered state.
//  Pairing: first accepted byte goes to hi register (have_hi=1). The second pushes
//   {hi,lo} to the FIFO and clears have_hi.
//  in_last on a byte that leaves have_hi=1 (odd length): hi byte is dropped,
//   odd_drop <= 1, have_hi <= 0. No padding character is ever issued.
//  Issue: on each edge where FIFO is non-empty and state is STREAM/FLUSH, pop the
//   head into 'character' and set step=1. Otherwise step=0 and 'character' holds
//   its last value.
//  Latency: the second byte of a pair is accepted at edge N. The FIFO write occurs
//   at N; the earliest step=1 with that character is in the cycle after edge N+1.
//  Push and pop in the same cycle are both performed; the count is unchanged.
//  FIFO full: in_ready=0, so no overflow is possible. FIFO empty: no pop, step=0.
//  Character index: an internal counter equals the index of the character on
//   'character' while step=1, and increments after each step.
//   char_count = number of steps, saturating at all-ones.
//  Report: if step && result, the next cycle has report_valid=1 and report_offset =
//   that character's index. result is ignored when step=0. report_offset holds
//   between strobes.
//  done rises in the cycle after FLUSH->DONE and stays 1 until start.
//  reset_n low mid-stream: immediate return to reset values. No partial character
//   or report is issued after release.
// TESTING
//  Bytes "AACCCC" (41 41 43 43 43 43), last on byte 6 -> characters 4141,4343,4343
//   with step; char_count=3; done=1; odd_drop=0.
//  Same stream into matcher, result=1 on idx1,2 -> report_valid pulses with offsets
//   1 then 2, each one cycle after the step.
//  5-byte stream 41 41 43 43 43(last) -> 2 characters; odd_drop=1; no third step.
//  Stall consumer impossible. Hold in_valid=1 for 20 bytes with FIFO_DEPTH=2 ->
//   in_ready never drops while steps drain; if forced full, in_ready=0 and no
//   byte is lost.
//  reset_n pulsed low after 3 bytes -> all outputs 0 immediately; after start, a new
//   stream begins at index 0.
//  start asserted during STREAM -> ignored; count and FIFO contents are unchanged.

Source files
------------

// File: rtl/symbol_stream_feeder.sv
// Host-side feeder for the STE automaton matcher: packs bytes into 16-bit characters,
// issues them one per cycle with a step enable, and turns matcher results into offset reports.
module symbol_stream_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0]      character,
    output logic             step,
    input  logic             result,
    output logic             report_valid,
    output logic [CNT_W-1:0] report_offset,
    output logic [CNT_W-1:0] char_count,
    output logic             odd_drop,
    output logic             done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   LVL_ZERO  = (PTR_W + 1)'(1'b0);
    localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [15:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   level_r;
    logic [7:0]       hi_r;
    logic             have_hi_r;
    logic [15:0]      character_r;
    logic             step_r;
    logic             report_valid_r;
    logic [CNT_W-1:0] report_offset_r;
    logic [CNT_W-1:0] idx_r;
    logic [CNT_W-1:0] char_count_r;
    logic             odd_drop_r;
    logic             done_r;

    logic fifo_empty_s;
    logic fifo_full_s;
    logic in_ready_s;
    logic accept_s;
    logic push_s;
    logic pop_s;
    logic start_ok_s;

    assign fifo_empty_s = (level_r == LVL_ZERO);
    assign fifo_full_s  = (level_r == FIFO_FULL);
    assign in_ready_s   = (state_r == ST_STREAM) && !fifo_full_s;
    assign accept_s     = in_valid && in_ready_s;
    assign push_s       = accept_s && have_hi_r;
    assign pop_s        = ((state_r == ST_STREAM) || (state_r == ST_FLUSH)) && !fifo_empty_s;
    assign start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // Next-state logic for the stream lifecycle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_STREAM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && in_last) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                // step_r must also be low so the final character's cycle completes first
                if (fifo_empty_s && !step_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                if (start) begin
                    next_state_s = ST_STREAM;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Byte pairing and odd-length tracking
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_r       <= 8'h00;
            have_hi_r  <= 1'b0;
            odd_drop_r <= 1'b0;
        end else if (start_ok_s) begin
            have_hi_r  <= 1'b0;
            odd_drop_r <= 1'b0;
        end else if (accept_s) begin
            if (have_hi_r) begin
                have_hi_r <= 1'b0;
            end else if (in_last) begin
                // unpaired final byte is discarded, never padded
                have_hi_r  <= 1'b0;
                odd_drop_r <= 1'b1;
            end else begin
                hi_r      <= in_data;
                have_hi_r <= 1'b1;
            end
        end
    end

    // Character FIFO storage, pointers and fill level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else if (start_ok_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {hi_r, in_data};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Issue stage: present the FIFO head to the matcher with a step enable
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            character_r <= 16'h0000;
            step_r      <= 1'b0;
        end else begin
            step_r <= pop_s;
            if (pop_s) begin
                character_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Character index and saturating step counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_r        <= CNT_ZERO;
            char_count_r <= CNT_ZERO;
        end else if (start_ok_s) begin
            idx_r        <= CNT_ZERO;
            char_count_r <= CNT_ZERO;
        end else if (step_r) begin
            idx_r <= idx_r + CNT_ONE;
            if (char_count_r != CNT_MAX) begin
                char_count_r <= char_count_r + CNT_ONE;
            end
        end
    end

    // Report records: idx_r still names the stepped character during its step cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            report_valid_r  <= 1'b0;
            report_offset_r <= CNT_ZERO;
        end else begin
            report_valid_r <= step_r && result;
            if (step_r && result) begin
                report_offset_r <= idx_r;
            end
        end
    end

    // Done flag, held until the next accepted start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_r <= 1'b0;
        end else if (start_ok_s) begin
            done_r <= 1'b0;
        end else if ((state_r == ST_FLUSH) && (next_state_s == ST_DONE)) begin
            done_r <= 1'b1;
        end
    end

    assign in_ready      = in_ready_s;
    assign character     = character_r;
    assign step          = step_r;
    assign report_valid  = report_valid_r;
    assign report_offset = report_offset_r;
    assign char_count    = char_count_r;
    assign odd_drop      = odd_drop_r;
    assign done          = done_r;

endmodule

// File: tb/tb_symbol_stream_feeder.sv
// Randomized self-checking bench for symbol_stream_feeder against a queue-based stream model.
module tb_symbol_stream_feeder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [15:0]      character;
    logic             step;
    logic             result = 1'b0;
    logic             report_valid;
    logic [CNT_W-1:0] report_offset;
    logic [CNT_W-1:0] char_count;
    logic             odd_drop;
    logic             done;

    symbol_stream_feeder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .character(character), .step(step), .result(result),
        .report_valid(report_valid), .report_offset(report_offset),
        .char_count(char_count), .odd_drop(odd_drop), .done(done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected characters in order with the edge they were paired on
    logic [15:0] exp_char_q [$];
    int          exp_edge_q [$];
    logic [7:0]  hi_m;
    bit          have_hi_m = 0;
    bit          odd_m = 0;
    bit          streaming_m = 0;
    bit          idle_m = 1;
    int          steps_m = 0;
    bit          rep_pend_m = 0;
    int          rep_off_m = 0;
    int          edge_cnt = 0;
    bit          res_idx12 = 0;
    logic [7:0]  stream_bytes [64];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_char_q.delete();
        exp_edge_q.delete();
        have_hi_m  = 0;
        odd_m      = 0;
        steps_m    = 0;
        rep_pend_m = 0;
    endtask

    // One clock: check pre-edge in_ready, advance, update model, check outputs, pick result
    task automatic tick();
        bit         acc;
        bit         lst;
        bit         st_eff;
        bit         r;
        logic [7:0] d;
        logic [15:0] c;
        int         e;
        acc    = in_valid && in_ready;
        lst    = in_last;
        d      = in_data;
        st_eff = start && idle_m;
        check_eq("in_ready", in_ready, streaming_m);
        @(posedge clock);
        edge_cnt++;
        #1;
        if (st_eff) begin
            model_clear();
            streaming_m = 1;
            idle_m      = 0;
            check_eq("done_cleared", done, 0);
        end
        if (acc) begin
            if (have_hi_m) begin
                exp_char_q.push_back({hi_m, d});
                exp_edge_q.push_back(edge_cnt);
                have_hi_m = 0;
            end else if (lst) begin
                odd_m = 1;
            end else begin
                hi_m      = d;
                have_hi_m = 1;
            end
            if (lst) streaming_m = 0;
        end
        check_eq("report_valid", report_valid, rep_pend_m);
        if (rep_pend_m) check_eq("report_offset", report_offset, rep_off_m);
        check_eq("char_count", char_count, steps_m);
        check_eq("odd_drop", odd_drop, odd_m);
        if (done) begin
            check_eq("done_with_pending", exp_char_q.size(), 0);
            idle_m = 1;
        end
        rep_pend_m = 0;
        if (step) begin
            if (exp_char_q.size() == 0) begin
                check_eq("spurious_step", 1, 0);
                result = 1'b0;
            end else begin
                c = exp_char_q.pop_front();
                e = exp_edge_q.pop_front();
                check_eq("character", character, c);
                check_eq("step_latency", edge_cnt, e + 1);
                r = res_idx12 ? ((steps_m == 1) || (steps_m == 2)) : 1'($urandom_range(0, 1));
                result     = r;
                rep_pend_m = r;
                rep_off_m  = steps_m;
                steps_m++;
            end
        end else begin
            result = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_outs"}, {character, step, report_valid, odd_drop, done}, 0);
        check_eq({tag, "_counts"}, {report_offset, char_count}, 0);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset");
        model_clear();
        streaming_m = 0;
        idle_m      = 1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        start       = 1'b0;
        result      = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_stream(input int n, input int gap_pct, input bit idx12, input int noise_at);
        int sent;
        int cyc;
        bit a;
        sent      = 0;
        cyc       = 0;
        res_idx12 = idx12;
        start     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        tick();
        start = 1'b0;
        while (sent < n && cyc < 2000) begin
            cyc++;
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = stream_bytes[sent];
            in_last  = (sent == n - 1);
            start    = (cyc == noise_at);
            a        = in_valid && in_ready;
            tick();
            if (a) sent++;
        end
        check_eq("bytes_sent", sent, n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        cyc      = 0;
        while (!done && cyc < 200) begin
            cyc++;
            tick();
        end
        check_eq("done_timeout", done, 1);
        check_eq("final_count", char_count, n / 2);
        check_eq("final_odd", odd_drop, n % 2);
        check_eq("final_pending", exp_char_q.size(), 0);
        tick();
        tick();
        check_eq("done_held", done, 1);
    endtask

    initial begin
        int n;
        #3;
        check_all_zero("initial");
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // "AACCCC" with matcher hits on indices 1 and 2
        stream_bytes[0] = 8'h41; stream_bytes[1] = 8'h41;
        stream_bytes[2] = 8'h43; stream_bytes[3] = 8'h43;
        stream_bytes[4] = 8'h43; stream_bytes[5] = 8'h43;
        run_stream(6, 0, 1, 0);

        // Odd-length stream drops the trailing byte
        run_stream(5, 0, 0, 0);

        // Long back-to-back stream on a 2-deep FIFO with a stray start mid-stream
        for (int i = 0; i < 20; i++) stream_bytes[i] = 8'($urandom);
        run_stream(20, 0, 0, 7);

        // Reset after three bytes, then a fresh stream restarts at index 0
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) stream_bytes[i] = 8'($urandom);
        run_stream(6, 0, 1, 0);

        // Random streams with input gaps and random results
        for (int s = 0; s < 10; s++) begin
            n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) stream_bytes[i] = 8'($urandom);
            run_stream(n, 30, 0, (s % 3 == 0) ? 4 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
